// File: rtl/two_phase_clock_monitor.sv
// two_phase_clock_monitor: tracks a non-overlapping c1/c2 clock pair, measures phase widths,
// counts clean cycles and raises sticky overlap/order/width/timeout flags.
module two_phase_clock_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int MIN_HIGH    = 2,
    parameter int MAX_HIGH    = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             c1,
    input  logic             c2,
    input  logic             clear_err,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] c1_width,
    output logic [CNT_W-1:0] c2_width,
    output logic [15:0]      cycle_count,
    output logic             cycle_strobe,
    output logic             locked,
    output logic             err_overlap,
    output logic             err_order,
    output logic             err_width,
    output logic             err_timeout
);
    localparam logic [2:0] IDLE = 3'd0, PH1 = 3'd1, GAP12 = 3'd2, PH2 = 3'd3, GAP21 = 3'd4;
    localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] TO_W  = CNT_W'(TIMEOUT);

    logic [SYNC_STAGES-1:0] c1_sync, c2_sync;
    logic                   c1_d, c2_d;
    logic [2:0]             state, step, nxt;
    logic [CNT_W-1:0]       hi_cnt, idle_cnt;
    logic [1:0]             run;
    logic c1_s, c2_s, rise1, fall1, rise2, fall2, any_edge, in_ph, fall_ph;
    logic e_ovl, e_ord, e_wid, e_to, err, done;

    always_comb begin
        c1_s     = c1_sync[SYNC_STAGES-1];
        c2_s     = c2_sync[SYNC_STAGES-1];
        rise1    = c1_s & ~c1_d;
        fall1    = ~c1_s & c1_d;
        rise2    = c2_s & ~c2_d;
        fall2    = ~c2_s & c2_d;
        any_edge = rise1 | fall1 | rise2 | fall2;
        in_ph    = (state == PH1) | (state == PH2);
        fall_ph  = ((state == PH1) & fall1) | ((state == PH2) & fall2);
        e_ovl    = enable & c1_s & c2_s;
        e_ord    = enable & ((rise2 & ((state == IDLE) | (state == GAP21) | (state == PH1)))
                           | (rise1 & ((state == GAP12) | (state == PH2))));
        e_wid    = enable & in_ph & ((fall_ph & (hi_cnt < MIN_W)) | (hi_cnt > MAX_W));
        e_to     = enable & (state != IDLE) & (idle_cnt >= TO_W);
        err      = e_ovl | e_ord | e_wid | e_to;
        step     = ((state == IDLE) & rise1 & ~c2_s) ? PH1 :
                   ((state == PH1) & fall1)          ? GAP12 :
                   ((state == GAP12) & rise2)        ? PH2 :
                   ((state == PH2) & fall2)          ? GAP21 :
                   ((state == GAP21) & rise1)        ? PH1 : state;
        nxt      = (!enable || err) ? IDLE : step;
        done     = enable & ~err & (state == PH2) & fall2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c1_sync <= '0;
            c2_sync <= '0;
            c1_d    <= 1'b0;
            c2_d    <= 1'b0;
        end else begin
            c1_sync <= {c1_sync[SYNC_STAGES-2:0], c1};
            c2_sync <= {c2_sync[SYNC_STAGES-2:0], c2};
            c1_d    <= c1_s;
            c2_d    <= c2_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hi_cnt       <= '0;
            idle_cnt     <= '0;
            c1_width     <= '0;
            c2_width     <= '0;
            cycle_count  <= '0;
            cycle_strobe <= 1'b0;
            run          <= '0;
            err_overlap  <= 1'b0;
            err_order    <= 1'b0;
            err_width    <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= nxt;
            cycle_strobe <= done;
            // a newly detected error wins over a coincident clear
            err_overlap  <= e_ovl | (err_overlap & ~clear_err);
            err_order    <= e_ord | (err_order & ~clear_err);
            err_width    <= e_wid | (err_width & ~clear_err);
            err_timeout  <= e_to | (err_timeout & ~clear_err);
            run          <= (!enable || err) ? 2'd0 : (done && run != 2'd2) ? run + 2'd1 : run;
            if (enable) begin
                idle_cnt <= (any_edge || state == IDLE) ? '0 : (idle_cnt != '1) ? idle_cnt + 1'b1 : idle_cnt;
                hi_cnt   <= ((nxt == PH1 || nxt == PH2) && nxt != state) ? CNT_W'(1) :
                            (in_ph && hi_cnt != '1) ? hi_cnt + 1'b1 : hi_cnt;
                if (state == PH1 && fall1)
                    c1_width <= hi_cnt;
                if (state == PH2 && fall2)
                    c2_width <= hi_cnt;
                if (done)
                    cycle_count <= cycle_count + 16'd1;
            end
        end
    end

    assign phase  = state;
    assign locked = (run == 2'd2);
endmodule
